// File: rtl/tlu_word_serializer.sv
// tlu_word_serializer: pops 32-bit TLU words and streams them as FWFT 16-bit half-words on BUS_CLK.
// Optional delivered-word counter at addr 2..5 when TLU_SERIALIZER_CNT_EN is defined.
module tlu_word_serializer #(
  parameter int         ABUSWIDTH = 16,
  parameter logic [7:0] VERSION   = 8'd1
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_WR,
  input  logic                 BUS_RD,
  input  logic                 IN_EMPTY,
  input  logic [31:0]          IN_DATA,
  output logic                 IN_READ,
  output logic                 FIFO_EMPTY_OUT,
  output logic [15:0]          FIFO_DATA_OUT,
  input  logic                 FIFO_READ_NEXT_IN
);
  typedef enum logic [1:0] {S_EMPTY, S_FIRST, S_SECOND} state_t;
  state_t      state_q, state_d;
  logic [31:0] word_q;
  logic        enable_q, hi_first_q;
  logic [7:0]  bus_data_q, rd_d, cnt_byte;
  logic        irst, load;
  logic        unused_ok;
  assign unused_ok = ^BUS_DATA_IN[7:2];
  assign irst = RST | (BUS_WR & (BUS_ADD == '0));
  assign load = enable_q & ~IN_EMPTY &
                ((state_q == S_EMPTY) | ((state_q == S_SECOND) & FIFO_READ_NEXT_IN));
  assign IN_READ = load & ~irst;
  assign FIFO_EMPTY_OUT = state_q == S_EMPTY;
  assign FIFO_DATA_OUT = ((state_q == S_SECOND) ^ hi_first_q) ? word_q[31:16] : word_q[15:0];
  assign BUS_DATA_OUT = bus_data_q;
  always_comb begin
    state_d = load ? S_FIRST
            : FIFO_READ_NEXT_IN ? ((state_q == S_FIRST) ? S_SECOND : S_EMPTY)
            : state_q;
  end
  always_ff @(posedge BUS_CLK) begin
    if (irst) begin
      state_q    <= S_EMPTY;
      word_q     <= '0;
      enable_q   <= 1'b0;
      hi_first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) word_q <= IN_DATA;
      if (BUS_WR && BUS_ADD == ABUSWIDTH'(1)) {hi_first_q, enable_q} <= BUS_DATA_IN[1:0];
    end
  end
`ifdef TLU_SERIALIZER_CNT_EN
  logic [31:0] cnt_q, shadow_q;
  // reading the LSB snapshots the whole counter so bytes 1..3 stay coherent
  always_ff @(posedge BUS_CLK) begin
    if (irst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      if ((state_q == S_SECOND) && FIFO_READ_NEXT_IN) cnt_q <= cnt_q + 32'd1;
      if (BUS_RD && BUS_ADD == ABUSWIDTH'(2)) shadow_q <= cnt_q;
    end
  end
  always_comb begin
    cnt_byte = (BUS_ADD == ABUSWIDTH'(2)) ? cnt_q[7:0]
             : (BUS_ADD == ABUSWIDTH'(3)) ? shadow_q[15:8]
             : (BUS_ADD == ABUSWIDTH'(4)) ? shadow_q[23:16]
             : (BUS_ADD == ABUSWIDTH'(5)) ? shadow_q[31:24]
             : 8'h00;
  end
`else
  assign cnt_byte = 8'h00;
`endif
  always_comb begin
    rd_d = (BUS_ADD == '0) ? VERSION
         : (BUS_ADD == ABUSWIDTH'(1)) ? {6'b0, hi_first_q, enable_q}
         : cnt_byte;
  end
  always_ff @(posedge BUS_CLK) begin
    if (RST) bus_data_q <= 8'h00;
    else if (BUS_RD) bus_data_q <= rd_d;
  end
endmodule

// File: tb/tb_tlu_word_serializer.sv
// tb_tlu_word_serializer: scoreboard bench for tlu_word_serializer (upstream queue model, half-word scoreboard).
module tb_tlu_word_serializer;
  logic        clk = 0, rst = 1;
  logic [15:0] bus_add = '0;
  logic [7:0]  bus_din = '0, bus_dout;
  logic        bus_wr = 0, bus_rd = 0;
  logic        in_empty = 1, in_read;
  logic [31:0] in_data = '0;
  logic        f_empty, rn = 0;
  logic [15:0] f_data;
  int          checks = 0, errors = 0;
  logic [31:0] up_q[$];
  logic [16:0] exp_q[$];
  logic        hi = 0, last_ir = 0, held = 0;
  logic [15:0] held_data = '0;
  int          cnt_m = 0, acc = 0, rd_count = 0;
  always #5 clk = ~clk;
  tlu_word_serializer #(.ABUSWIDTH(16), .VERSION(8'd1)) dut (
    .BUS_CLK(clk), .RST(rst), .BUS_ADD(bus_add), .BUS_DATA_IN(bus_din), .BUS_DATA_OUT(bus_dout),
    .BUS_WR(bus_wr), .BUS_RD(bus_rd), .IN_EMPTY(in_empty), .IN_DATA(in_data), .IN_READ(in_read),
    .FIFO_EMPTY_OUT(f_empty), .FIFO_DATA_OUT(f_data), .FIFO_READ_NEXT_IN(rn)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic void refresh();
    in_empty = up_q.size() == 0;
    in_data  = in_empty ? 32'h0 : up_q[0];
  endfunction
  task automatic push(input logic [31:0] w, input bit expect_it);
    up_q.push_back(w);
    if (expect_it) begin
      exp_q.push_back({1'b0, hi ? w[31:16] : w[15:0]});
      exp_q.push_back({1'b1, hi ? w[15:0] : w[31:16]});
    end
    refresh();
  endtask
  task automatic step();
    logic [16:0] e;
    @(negedge clk);
    if (held) begin
      chk("hold_valid", {31'b0, f_empty}, 32'd0);
      chk("hold_data", {16'b0, f_data}, {16'b0, held_data});
    end
    held = !f_empty && !rn;
    held_data = f_data;
    if (!f_empty && rn) begin
      acc++;
      if (exp_q.size() == 0) chk("sb_extra", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("sb_data", {16'b0, f_data}, {16'b0, e[15:0]});
        if (e[16]) cnt_m++;
      end
    end
    last_ir = in_read;
    if (in_read) rd_count++;
    @(posedge clk);
    #1;
    if (last_ir) begin
      if (up_q.size() == 0) chk("read_on_empty", 32'd1, 32'd0);
      else void'(up_q.pop_front());
    end
    refresh();
  endtask
  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus_add = a; bus_din = d; bus_wr = 1;
    step();
    bus_wr = 0;
    if (a == 16'd0) begin cnt_m = 0; held = 0; end
  endtask
  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    bus_add = a; bus_rd = 1;
    step();
    bus_rd = 0;
    d = bus_dout;
  endtask
  task automatic read_cnt(output logic [31:0] v);
    logic [7:0] b0, b1, b2, b3;
    bus_read(16'd2, b0); bus_read(16'd3, b1); bus_read(16'd4, b2); bus_read(16'd5, b3);
    v = {b3, b2, b1, b0};
  endtask
  function automatic logic [31:0] cnt_exp(input logic [31:0] c);
`ifdef TLU_SERIALIZER_CNT_EN
    return c;
`else
    return 32'd0 & c;
`endif
  endfunction
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0]  d;
    logic [31:0] v;
    int a0, r0;
    repeat (3) step();
    chk("rst_empty", {31'b0, f_empty}, 32'd1);
    chk("rst_in_read", {31'b0, in_read}, 32'd0);
    chk("rst_data", {16'b0, f_data}, 32'd0);
    chk("rst_bus_out", {24'b0, bus_dout}, 32'd0);
    rst = 0;
    bus_read(16'd0, d); chk("version", {24'b0, d}, 32'd1);
    bus_read(16'd1, d); chk("ctrl_rst", {24'b0, d}, 32'd0);
    bus_read(16'd7, d); chk("addr7", {24'b0, d}, 32'd0);
    read_cnt(v); chk("cnt_rst", v, 32'd0);
    // basic low-half-first word
    hi = 0; bus_write(16'd1, 8'h01); rn = 1;
    push(32'h12345678, 1);
    step(); chk("t1_in_read", {31'b0, last_ir}, 32'd1); chk("t1_valid", {31'b0, f_empty}, 32'd0);
    step(); step();
    chk("t1_empty", {31'b0, f_empty}, 32'd1); chk("t1_sb", exp_q.size(), 32'd0);
    // high-half-first word
    bus_write(16'd1, 8'h00); hi = 1; bus_write(16'd1, 8'h02); bus_write(16'd1, 8'h03);
    push(32'hAABBCCDD, 1);
    repeat (3) step();
    chk("t2_empty", {31'b0, f_empty}, 32'd1); chk("t2_sb", exp_q.size(), 32'd0);
    bus_write(16'd1, 8'h00); hi = 0;
    // 100 back-to-back words
    bus_write(16'd0, 8'h00); bus_write(16'd1, 8'h01);
    for (int i = 0; i < 100; i++) push($urandom, 1);
    rn = 1;
    step(); a0 = acc;
    repeat (200) step();
    chk("t3_no_bubble", acc - a0, 32'd200);
    chk("t3_empty", {31'b0, f_empty}, 32'd1); chk("t3_sb", exp_q.size(), 32'd0);
    read_cnt(v); chk("t3_cnt", v, cnt_exp(32'd100));
    // throttled READ_NEXT
    for (int i = 0; i < 30; i++) push($urandom, 1);
    for (int i = 0; i < 3000 && exp_q.size() > 0; i++) begin
      rn = $urandom_range(0, 9) < 3;
      step();
    end
    chk("t4_drained", exp_q.size(), 32'd0); chk("t4_empty", {31'b0, f_empty}, 32'd1);
    read_cnt(v); chk("t4_cnt", v, cnt_exp(cnt_m));
    // ENABLE cleared mid-word
    rn = 1;
    push(32'h0000BEEF, 1); push(32'h11111111, 0); push(32'h22222222, 0);
    step(); chk("t5_in_read", {31'b0, last_ir}, 32'd1);
    bus_write(16'd1, 8'h00);
    r0 = rd_count;
    repeat (6) step();
    chk("t5_no_read", rd_count - r0, 32'd0); chk("t5_up_left", up_q.size(), 32'd2);
    chk("t5_sb", exp_q.size(), 32'd0); chk("t5_empty", {31'b0, f_empty}, 32'd1);
    up_q.delete(); refresh();
    // soft reset while second half is pending
    bus_write(16'd1, 8'h01);
    push(32'hCAFEF00D, 1);
    step(); step(); rn = 0;
    chk("t6_pending", {31'b0, f_empty}, 32'd0);
    bus_write(16'd0, 8'h00);
    exp_q.delete();
    chk("t6_empty", {31'b0, f_empty}, 32'd1);
    bus_read(16'd1, d); chk("t6_ctrl", {24'b0, d}, 32'd0);
    read_cnt(v); chk("t6_cnt", v, 32'd0);
    bus_write(16'd1, 8'h01);
    push(32'h55555555, 0);
    bus_write(16'd0, 8'h00);
    chk("t6_rst_no_read", {31'b0, last_ir}, 32'd0);
    chk("t6_up_kept", up_q.size(), 32'd1);
    chk("t6_empty2", {31'b0, f_empty}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
